// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates the single-ported, fixed-latency unified memory
//               between the instruction-fetch port and the data (LW/SW)
//               port. Grants one port at a time, sequences the multi-cycle
//               access, returns a single-cycle ack with read data, and stops
//               new fetch grants while halt is high.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int c_cnt_w = $clog2(MEM_LAT + 1);
    localparam logic [c_cnt_w-1:0] c_lat = c_cnt_w'(MEM_LAT);
    localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_last_d;     // 1 when D won the most recent tie
    logic [ADDR_W-1:0]   r_hold_addr;
    logic                r_hold_we;
    logic [DATA_W-1:0]   r_hold_wdata;

    logic w_elig_if;
    logic w_elig_d;
    logic w_contest;
    logic w_grant_if;
    logic w_grant_d;
    logic w_busy;
    logic w_done;

    // Request eligibility and round-robin tie break (halt masks fetch only)
    always_comb begin
        w_elig_d   = d_req;
        w_elig_if  = if_req & ~halt;
        w_contest  = w_elig_d & w_elig_if;
        w_grant_d  = w_elig_d & (~w_elig_if | ~r_last_d);
        w_grant_if = w_elig_if & ~w_grant_d;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: grant from IDLE, always fall back to IDLE after completion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = BUSY_D;
                end else if (w_grant_if) begin
                    w_state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (r_cnt == c_lat) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Access counter, fairness flag and payload hold registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_last_d     <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_we    <= 1'b0;
            r_hold_wdata <= '0;
        end else if (r_state == IDLE) begin
            if (w_grant_d) begin
                r_hold_addr  <= d_addr;
                r_hold_we    <= d_we;
                r_hold_wdata <= d_wdata;
                r_cnt        <= c_one;
                if (w_contest) begin
                    r_last_d <= 1'b1;
                end
            end else if (w_grant_if) begin
                r_hold_addr  <= if_addr;
                r_hold_we    <= 1'b0;
                r_hold_wdata <= '0;
                r_cnt        <= c_one;
                if (w_contest) begin
                    r_last_d <= 1'b0;
                end
            end
        end else begin
            // Counter parks at zero once the access finishes
            r_cnt <= (r_cnt == c_lat) ? '0 : r_cnt + c_one;
        end
    end

    // Memory strobes and completion decode, all from registered state
    always_comb begin
        w_busy    = (r_state == BUSY_IF) || (r_state == BUSY_D);
        w_done    = w_busy && (r_cnt == c_lat);
        busy      = w_busy;
        mem_en    = w_busy && (r_cnt == c_one);
        mem_we    = w_busy ? r_hold_we    : 1'b0;
        mem_addr  = w_busy ? r_hold_addr  : '0;
        mem_wdata = w_busy ? r_hold_wdata : '0;
        if_ack    = w_done && (r_state == BUSY_IF);
        d_ack     = w_done && (r_state == BUSY_D);
        if_rdata  = if_ack ? mem_rdata : '0;
        // A store returns no data
        d_rdata   = (d_ack && !r_hold_we) ? mem_rdata : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (MEM_LAT = 4).
//               Cycle 0 is the cycle in which a request is first presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ADDR_W (16),
        .DATA_W (16),
        .MEM_LAT(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .halt     (halt),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; halt = 1'b0;
        if_req = 1'b0; if_addr = 16'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
        mem_rdata = 16'h0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_outs", {mem_en, mem_we, if_ack, d_ack}, 32'd0);
        chk("rst_bus", {mem_addr, mem_wdata}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // ---------------- single load + mid-access address change ----------------
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040; mem_rdata = 16'hBEEF;
        chk("ld_c0_busy", {31'b0, busy}, 32'd0);
        tick(); // cycle 1
        chk("ld_c1_ctl", {busy, mem_en, mem_we, d_ack}, 32'b1100);
        chk("ld_c1_addr", {16'b0, mem_addr}, 32'h0040);
        tick(); // cycle 2
        chk("ld_c2_en", {31'b0, mem_en}, 32'd0);
        d_addr = 16'h0555;
        tick(); // cycle 3
        chk("ld_c3_addr_held", {16'b0, mem_addr}, 32'h0040);
        chk("ld_c3_ack", {31'b0, d_ack}, 32'd0);
        tick(); // cycle 4
        chk("ld_c4_ack", {if_ack, d_ack}, 32'b01);
        chk("ld_c4_rdata", {16'b0, d_rdata}, 32'hBEEF);
        d_req = 1'b0;
        tick(); // cycle 5
        chk("ld_c5_idle", {busy, d_ack}, 32'd0);
        chk("ld_c5_rdata", {16'b0, d_rdata}, 32'd0);

        // ---------------- store ----------------
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234; mem_rdata = 16'hFFFF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("st_c%0d_we_wdata", c), {15'b0, mem_we, mem_wdata}, {15'b0, 1'b1, 16'h1234});
            chk($sformatf("st_c%0d_ack", c), {if_ack, d_ack}, (c == 4) ? 32'b01 : 32'b00);
        end
        chk("st_c4_rdata", {16'b0, d_rdata}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick(); // cycle 5
        chk("st_c5_idle", {31'b0, busy}, 32'd0);

        // ---------------- contention fairness from reset ----------------
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 16'h0A00;
        d_req = 1'b1; d_addr = 16'h0D00; d_we = 1'b0; mem_rdata = 16'h0A0A;
        tick();
        rst_n = 1'b1; // cycle 0: both requesting, D wins first tie
        for (int c = 1; c <= 19; c++) begin
            tick();
            chk($sformatf("ct_c%0d_acks", c), {if_ack, d_ack},
                (c == 4 || c == 14) ? 32'b01 : (c == 9 || c == 19) ? 32'b10 : 32'b00);
            if (c == 1 || c == 11)
                chk($sformatf("ct_c%0d_addr", c), {16'b0, mem_addr}, 32'h0D00);
            if (c == 6 || c == 16)
                chk($sformatf("ct_c%0d_addr", c), {16'b0, mem_addr}, 32'h0A00);
            if (c == 5 || c == 10 || c == 15)
                chk($sformatf("ct_c%0d_idle", c), {31'b0, busy}, 32'd0);
        end
        chk("ct_c19_ifdata", {16'b0, if_rdata}, 32'h0A0A);
        chk("ct_c19_ddata", {16'b0, d_rdata}, 32'd0);
        if_req = 1'b0; d_req = 1'b0;
        tick(); // cycle 20
        tick();
        chk("ct_after_idle", {31'b0, busy}, 32'd0);

        // ---------------- halt ----------------
        halt = 1'b1; if_req = 1'b1; if_addr = 16'h0300;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("halt_nogrant%0d", c), {busy, mem_en}, 32'd0);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200; mem_rdata = 16'h7777; // cycle 0
        tick(); // cycle 1
        chk("halt_d_c1", {busy, mem_en}, 32'b11);
        chk("halt_d_addr", {16'b0, mem_addr}, 32'h0200);
        tick(); tick(); tick(); // cycle 4
        chk("halt_d_ack", {if_ack, d_ack}, 32'b01);
        chk("halt_d_rdata", {16'b0, d_rdata}, 32'h7777);
        d_req = 1'b0;
        tick(); // cycle 5
        tick(); // cycle 6
        chk("halt_still_idle", {31'b0, busy}, 32'd0);
        halt = 1'b0;
        mem_rdata = 16'h1357;
        tick(); // cycle 7: fetch granted at end of cycle 6
        chk("unhalt_grant", {busy, mem_en, mem_we}, 32'b110);
        chk("unhalt_addr", {16'b0, mem_addr}, 32'h0300);
        tick(); // cycle 8: halt rises and if_req drops during BUSY_IF
        halt = 1'b1; if_req = 1'b0;
        tick(); // cycle 9
        chk("if_c9_noack", {31'b0, if_ack}, 32'd0);
        tick(); // cycle 10
        chk("if_ack_inflight", {if_ack, d_ack}, 32'b10);
        chk("if_rdata", {16'b0, if_rdata}, 32'h1357);
        halt = 1'b0;
        tick(); // cycle 11
        tick();
        chk("if_done_idle", {busy, if_ack}, 32'd0);

        // ---------------- async reset mid BUSY_D ----------------
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0044; d_wdata = 16'hCAFE;
        tick(); tick(); // cycle 2
        chk("ar_busy_before", {busy, mem_we}, 32'b11);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_ctl_now", {busy, mem_en, mem_we, d_ack, if_ack}, 32'd0);
        chk("ar_bus_now", {mem_addr, mem_wdata}, 32'd0);
        tick(); tick(); // past where ack would have been
        chk("ar_no_ack", {31'b0, d_ack}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;
        tick(); tick();
        chk("ar_post_idle", {busy, mem_en, d_ack}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound the run so a stalled bench still terminates
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
